// File: rtl/acq_trig_ctrl.sv
// acq_trig_ctrl: acquisition sequencer for the ADC capture ring buffer.
// Drives the capture RAM write strobe and address, enforces the pre-trigger fill,
// counts post-trigger samples, records the trigger address and holds the frame for readout.
// Optional feature: define ACQ_TRG_AUTO_EN to add the auto_tmo port and timeout-forced
// triggers. Without it trig_forced is tied low and WAIT lasts until trg.
module acq_trig_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              mode_norm,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] posttrig,
`ifdef ACQ_TRG_AUTO_EN
  input  logic [TMO_W-1:0]  auto_tmo,
`endif
  input  logic              trg,
  input  logic              rd_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              trig_forced
);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;    // writes remaining in PRE or POST
  logic [ADDR_W-1:0] post_q, post_d;  // latched post-trigger length
  logic              norm_q, norm_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start;           // arm from IDLE or rearm from DONE
  logic              tmo_hit;

`ifdef ACQ_TRG_AUTO_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  wcnt_q, wcnt_d;  // WAIT cycle number, 1 on the first WAIT cycle
  logic              forced_q, forced_d;
`endif

  // Next-state, address and configuration latch logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    cnt_d       = cnt_q;
    post_d      = post_q;
    norm_d      = norm_q;
    start       = 1'b0;
    tmo_hit     = 1'b0;
`ifdef ACQ_TRG_AUTO_EN
    tmo_d       = tmo_q;
    wcnt_d      = wcnt_q;
    forced_d    = forced_q;
    tmo_hit     = (state_q == StWait) && (tmo_q != '0) && (wcnt_q == tmo_q);
`endif

    unique case (state_q)
      StIdle: begin
        start = arm;
      end
      StPre: begin
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - ADDR_W'(1);
        end
      end
      StWait: begin
        addr_d = addr_q + ADDR_W'(1);
        if (trg || tmo_hit) begin
          // The write in this cycle is the trigger sample.
          trig_addr_d = addr_q;
          if (post_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StPost;
            cnt_d   = post_q;
          end
        end
`ifdef ACQ_TRG_AUTO_EN
        // A real trg in the timeout cycle wins, so forced stays clear.
        if (!trg && tmo_hit) begin
          forced_d = 1'b1;
        end
        wcnt_d = wcnt_q + TMO_W'(1);
`endif
      end
      StPost: begin
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - ADDR_W'(1);
        end
      end
      StDone: begin
        if (rd_ack) begin
          if (norm_q) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      cnt_d   = pretrig;
      post_d  = posttrig;
      norm_d  = mode_norm;
      state_d = (pretrig == '0) ? StWait : StPre;
`ifdef ACQ_TRG_AUTO_EN
      tmo_d    = auto_tmo;
      forced_d = 1'b0;
`endif
    end

`ifdef ACQ_TRG_AUTO_EN
    if ((state_d == StWait) && (state_q != StWait)) begin
      wcnt_d = TMO_W'(1);
    end
`endif

    // Abort overrides everything: addresses and latched configuration hold.
    if (abort) begin
      state_d     = StIdle;
      addr_d      = addr_q;
      trig_addr_d = trig_addr_q;
      cnt_d       = cnt_q;
      post_d      = post_q;
      norm_d      = norm_q;
`ifdef ACQ_TRG_AUTO_EN
      tmo_d       = tmo_q;
      wcnt_d      = wcnt_q;
      forced_d    = 1'b0;
`endif
    end
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    wr_en_d = (state_d == StPre) || (state_d == StWait) || (state_d == StPost);
    busy_d  = wr_en_d;
    done_d  = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      post_q      <= '0;
      norm_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      post_q      <= post_d;
      norm_q      <= norm_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef ACQ_TRG_AUTO_EN
  // Auto-trigger timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q    <= '0;
      wcnt_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      wcnt_q   <= wcnt_d;
      forced_q <= forced_d;
    end
  end

  assign trig_forced = forced_q;
`else
  // TMO_W only sizes the optional timeout; nothing is built from it here.
  if (TMO_W == 0) begin : g_no_tmo
  end

  assign trig_forced = 1'b0;
`endif

  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_acq_trig_ctrl.sv
// Testbench for acq_trig_ctrl: vector table, directed corner sequences and
// randomized frames checked against a frame-level arithmetic model.
module tb_acq_trig_ctrl;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst, arm, abort, mode_norm, trg, rd_ack;
  logic [AW-1:0] pretrig, posttrig;
  logic          wr_en, busy, done, trig_forced;
  logic [AW-1:0] wr_addr, trig_addr;
`ifdef ACQ_TRG_AUTO_EN
  logic [23:0]   auto_tmo;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acq_trig_ctrl #(.ADDR_W(AW), .TMO_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .mode_norm  (mode_norm),
    .pretrig    (pretrig),
    .posttrig   (posttrig),
`ifdef ACQ_TRG_AUTO_EN
    .auto_tmo   (auto_tmo),
`endif
    .trg        (trg),
    .rd_ack     (rd_ack),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .trig_addr  (trig_addr),
    .busy       (busy),
    .done       (done),
    .trig_forced(trig_forced)
  );

  typedef struct {
    logic          rst, arm, abort, trg, ack;
    logic [AW-1:0] pre, post;
    logic          en, bsy, dn;
    logic [AW-1:0] addr, taddr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] pack(input logic f, input logic en, input logic b,
                                       input logic d, input logic [AW-1:0] t,
                                       input logic [AW-1:0] a);
    return {f, en, b, d, t, a};
  endfunction

  function automatic logic [23:0] obs();
    return pack(trig_forced, wr_en, busy, done, trig_addr, wr_addr);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    arm = 1'b0; abort = 1'b0; trg = 1'b0; rd_ack = 1'b0; mode_norm = 1'b0;
`ifdef ACQ_TRG_AUTO_EN
    auto_tmo = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic void add(input logic r, input logic a, input logic ab, input logic t,
                              input logic k, input int pre, input int post, input logic en,
                              input logic b, input logic d, input int addr, input int taddr);
    vec_t v;
    v.rst = r; v.arm = a; v.abort = ab; v.trg = t; v.ack = k;
    v.pre = AW'(pre); v.post = AW'(post);
    v.en = en; v.bsy = b; v.dn = d; v.addr = AW'(addr); v.taddr = AW'(taddr);
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    int m_addr, m_taddr;

    rst = 1'b1;
    idle_inputs();
    pretrig = '0;
    posttrig = '0;

    // ---- Table: basic capture, arm+abort conflict, abort in POST, zero lengths ----
    add(1, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0);                           // cycle 0
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 4, 3, 1, 1, 0, k - 1, 0);
    add(0, 0, 0, 1, 0, 4, 3, 1, 1, 0, 9, 0);                           // cycle 10 trg
    for (int k = 11; k <= 13; k++) add(0, 0, 0, 0, 0, 4, 3, 1, 1, 0, k - 1, 9);
    add(0, 0, 0, 0, 0, 4, 3, 0, 0, 1, 13, 9);                          // cycle 14 done
    add(0, 0, 0, 0, 1, 4, 3, 0, 0, 1, 13, 9);                          // rd_ack
    add(0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 13, 9);
    add(0, 1, 1, 0, 0, 4, 3, 0, 0, 0, 13, 9);                          // arm+abort
    add(0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 13, 9);
    add(0, 1, 0, 0, 0, 4, 3, 0, 0, 0, 13, 9);                          // cycle 19 arm
    for (int k = 20; k <= 23; k++) add(0, 0, 0, 0, 0, 4, 3, 1, 1, 0, k - 7, 9);
    add(0, 0, 0, 1, 0, 4, 3, 1, 1, 0, 17, 9);                          // trg
    add(0, 0, 0, 0, 0, 4, 3, 1, 1, 0, 18, 17);
    add(0, 0, 1, 0, 0, 4, 3, 1, 1, 0, 19, 17);                         // abort in POST
    add(0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 19, 17);
    add(0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 19, 17);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                           // zero lengths
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; arm = tbl[i].arm; abort = tbl[i].abort;
      trg = tbl[i].trg; rd_ack = tbl[i].ack;
      pretrig = tbl[i].pre; posttrig = tbl[i].post;
      if (!tbl[i].rst)
        check($sformatf("table_row%0d", i), obs(),
              pack(1'b0, tbl[i].en, tbl[i].bsy, tbl[i].dn, tbl[i].taddr, tbl[i].addr));
      step();
    end

    // ---- trg during PRE is ignored; WAIT persists ----
    do_reset();
    pretrig = 10'd4; posttrig = 10'd3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      trg = (k == 2);
      check($sformatf("pre_trg_ignored_c%0d", k), {wr_en, busy, done}, 3'b110);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;

    // ---- Normal-mode rearm across the address wrap ----
    do_reset();
    pretrig = 10'd1000; posttrig = 10'd21; mode_norm = 1'b1; trg = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    check("wrap_done_reached", done, 1'b1);
    check("wrap_addr_at_ack", wr_addr, 10'd1022);
    check("wrap_taddr_first", trig_addr, 10'd1000);
    trg = 1'b0; pretrig = 10'd4; posttrig = 10'd3; rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("wrap_c1", {wr_en, done, wr_addr}, {2'b10, 10'd1022});
    step();
    check("wrap_c2", {wr_en, wr_addr}, {1'b1, 10'd1023});
    step();
    check("wrap_c3", {wr_en, wr_addr}, {1'b1, 10'd0});
    step();
    check("wrap_c4", {wr_en, wr_addr}, {1'b1, 10'd1});
    step();
    trg = 1'b1;
    check("wrap_c5_wait", {wr_en, wr_addr}, {1'b1, 10'd2});
    step();
    trg = 1'b0;
    check("wrap_taddr", {trig_addr, wr_addr}, {10'd2, 10'd3});
    step(); step(); step();
    check("wrap_done2", {done, wr_en, wr_addr, trig_addr}, {2'b10, 10'd6, 10'd2});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("wrap_abort_done", {done, busy}, 2'b00);

    // ---- Auto-trigger timeout ----
    do_reset();
    pretrig = 10'd4; posttrig = 10'd3; trg = 1'b0;
`ifdef ACQ_TRG_AUTO_EN
    auto_tmo = 24'd100;
`endif
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 1; k < 104; k++) step();
    check("auto_c104", {wr_en, wr_addr, trig_forced}, {1'b1, 10'd103, 1'b0});
    step();
`ifdef ACQ_TRG_AUTO_EN
    check("auto_c105", obs(), pack(1'b1, 1'b1, 1'b1, 1'b0, 10'd103, 10'd104));
    step(); step(); step();
    check("auto_done", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 10'd103, 10'd107));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("auto_abort_clears", {trig_forced, done, busy}, 3'b000);
`else
    check("noauto_c105", obs(), pack(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd104));
    for (int k = 105; k < 300; k++) step();
    check("noauto_c300", {done, wr_en, trig_forced}, 3'b010);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    // ---- Randomized single-shot frames against the frame model ----
    do_reset();
    m_addr = 0;
    m_taddr = 0;
    for (int f = 0; f < 40; f++) begin
      int pre, post, c, start, ptrig;
      logic tv [0:63];
      logic en_e, dn_e;
      int addr_e, taddr_e;
      pre = int'($urandom_range(0, 12));
      post = int'($urandom_range(0, 12));
      for (int k = 0; k < 64; k++) tv[k] = ($urandom_range(0, 3) == 0);
      tv[pre + 40] = 1'b1;
      c = pre + 1;
      while (!tv[c]) c++;
      start = m_addr;
      ptrig = m_taddr;
      pretrig = AW'(pre);
      posttrig = AW'(post);
      mode_norm = 1'b0;
      for (int k = 0; k <= c + post + 3; k++) begin
        arm = (k == 0);
        trg = (k < 64) ? tv[k] : 1'b0;
        rd_ack = (k == c + post + 2);
        en_e = (k >= 1) && (k <= c + post);
        dn_e = (k > c + post) && (k <= c + post + 2);
        addr_e = (k == 0) ? start : (en_e ? start + k - 1 : start + c + post);
        taddr_e = (k > c) ? start + c - 1 : ptrig;
        check($sformatf("rand_f%0d_c%0d", f, k), obs(),
              pack(1'b0, en_e, en_e, dn_e, AW'(taddr_e), AW'(addr_e)));
        step();
      end
      m_addr = (start + c + post) % 1024;
      m_taddr = (start + c - 1) % 1024;
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
